// File: rtl/rvcpu.sv
// Shared CPU core types: register index, issue FSM states and issue depth.
package rvcpu;

  localparam int NUM_REGS           = 32;
  localparam int REG_IDX_W          = $clog2(NUM_REGS);
  localparam int ISSUE_MAX_INFLIGHT = 4;

  typedef logic [REG_IDX_W-1:0] reg_t;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_BR_WAIT   = 2'd1,
    ST_WFI_DRAIN = 2'd2,
    ST_SLEEP     = 2'd3
  } issue_state_t;

  // x0 is hardwired zero and never tracked as a pending write.
  function automatic logic reg_nonzero(input reg_t r);
    return (r != {REG_IDX_W{1'b0}});
  endfunction

endpackage

// File: rtl/issue_ctrl_chk.sv
// Protocol checks for the issue controller: retire underflow, inflight bound,
// release of a register that has no outstanding write, x0 never busy.
module issue_ctrl_chk
  import rvcpu::*;
#(
  parameter int MaxInflight = ISSUE_MAX_INFLIGHT,
  parameter int NumRegs     = NUM_REGS,
  localparam int CW = $clog2(MaxInflight + 1)
) (
  input logic               clk,
  input logic               rst,
  input logic               issue_valid,
  input logic               rd_valid,
  input reg_t               rd,
  input logic               retire_valid,
  input logic               retire_rd_valid,
  input reg_t               retire_rd,
  input logic [CW-1:0]      inflight,
  input logic [NumRegs-1:0] busy
);

  // Sample protocol invariants every active cycle.
  always @(posedge clk) begin
    if (rst && retire_valid && !issue_valid) begin
      a_retire_underflow: assert (inflight != {CW{1'b0}});
    end
    if (rst && retire_valid && retire_rd_valid && reg_nonzero(retire_rd) &&
        !(issue_valid && rd_valid && (rd == retire_rd))) begin
      a_reg_underflow: assert (busy[retire_rd]);
    end
    if (rst) begin
      a_inflight_bound: assert (inflight <= CW'(MaxInflight));
      a_x0_idle: assert (!busy[0]);
    end
  end

endmodule

// File: rtl/issue_ctrl_scoreboard.sv
// Per-register outstanding-write counters with a registered busy vector.
// Register 0 is never tracked. A set and clr of the same register in one
// cycle cancel out.
module issue_ctrl_scoreboard #(
  parameter int NumRegs  = 32,
  parameter int MaxCount = 4,
  localparam int IW = $clog2(NumRegs),
  localparam int CW = $clog2(MaxCount + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               set,
  input  logic [IW-1:0]      set_rd,
  input  logic               clr,
  input  logic [IW-1:0]      clr_rd,
  output logic [NumRegs-1:0] busy
);

  logic [CW-1:0]      cnt_r      [NumRegs];
  logic [CW-1:0]      cnt_next_s [NumRegs];
  logic [NumRegs-1:0] busy_next_s;
  logic [NumRegs-1:0] busy_r;

  // Next counter values; saturate at both ends so a protocol error cannot wrap.
  always_comb begin
    cnt_next_s[0] = {CW{1'b0}};
    busy_next_s   = {NumRegs{1'b0}};
    for (int r = 1; r < NumRegs; r++) begin
      if (set && (set_rd == IW'(r)) && !(clr && (clr_rd == IW'(r)))) begin
        if (cnt_r[r] != CW'(MaxCount)) begin
          cnt_next_s[r] = cnt_r[r] + CW'(1);
        end else begin
          cnt_next_s[r] = cnt_r[r];
        end
      end else if (clr && (clr_rd == IW'(r)) && !(set && (set_rd == IW'(r)))) begin
        if (cnt_r[r] != {CW{1'b0}}) begin
          cnt_next_s[r] = cnt_r[r] - CW'(1);
        end else begin
          cnt_next_s[r] = cnt_r[r];
        end
      end else begin
        cnt_next_s[r] = cnt_r[r];
      end
      busy_next_s[r] = (cnt_next_s[r] != {CW{1'b0}});
    end
  end

  // Register counters and the busy vector together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NumRegs; r++) begin
        cnt_r[r] <= {CW{1'b0}};
      end
      busy_r <= {NumRegs{1'b0}};
    end else begin
      for (int r = 0; r < NumRegs; r++) begin
        cnt_r[r] <= cnt_next_s[r];
      end
      busy_r <= busy_next_s;
    end
  end

  assign busy = busy_r;

endmodule

// File: rtl/issue_ctrl.sv
// Decode-stage issue controller: RAW scoreboard stall, inflight limit,
// branch hold and WFI drain/sleep sequencing, IF->ID and ID->EX handshake.
module issue_ctrl
  import rvcpu::*;
#(
  parameter int MaxInflight = ISSUE_MAX_INFLIGHT,
  parameter int NumRegs     = NUM_REGS,
  localparam int CW = $clog2(MaxInflight + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  reg_t               rs1,
  input  logic               rs1_valid,
  input  reg_t               rs2,
  input  logic               rs2_valid,
  input  reg_t               rd,
  input  logic               rd_valid,
  input  logic               is_branch,
  input  logic               is_jal,
  input  logic               is_wfi,
  input  logic               ex_ready,
  input  logic               br_resolve,
  input  logic               flush,
  input  logic               retire_valid,
  input  reg_t               retire_rd,
  input  logic               retire_rd_valid,
  input  logic               irq,
  output logic               issue_valid,
  output logic               id_ready,
  output logic               stall_hazard,
  output logic               sleeping,
  output logic [CW-1:0]      inflight,
  output logic [NumRegs-1:0] busy
);

  issue_state_t       state_r;
  logic               sleeping_r;
  logic [CW-1:0]      inflight_r;
  logic [NumRegs-1:0] busy_s;
  logic               stall_s;
  logic               issue_s;
  logic               ready_s;
  logic               sb_set_s;
  logic               sb_clr_s;

  // Issue decision; hazards use registered busy bits only (no retire bypass).
  // Gated by rst so nothing issues while reset is held.
  always_comb begin
    stall_s = id_valid && ((rs1_valid && busy_s[rs1]) || (rs2_valid && busy_s[rs2]));
    issue_s = rst && id_valid && (state_r == ST_RUN) && !stall_s && ex_ready &&
              (inflight_r < CW'(MaxInflight)) && !flush;
    ready_s = !id_valid || (rst && (issue_s || flush));
    sb_set_s = issue_s && rd_valid && reg_nonzero(rd);
    sb_clr_s = retire_valid && retire_rd_valid && reg_nonzero(retire_rd);
  end

  // Issue FSM; flush returns to RUN from anywhere, irq beats drain completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_RUN;
      sleeping_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          sleeping_r <= 1'b0;
          if (issue_s && (is_branch || is_jal)) begin
            state_r <= ST_BR_WAIT;
          end else if (issue_s && is_wfi) begin
            state_r <= ST_WFI_DRAIN;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_BR_WAIT: begin
          sleeping_r <= 1'b0;
          if (br_resolve || flush) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_BR_WAIT;
          end
        end
        ST_WFI_DRAIN: begin
          if (flush || irq) begin
            state_r    <= ST_RUN;
            sleeping_r <= 1'b0;
          end else if ((inflight_r == {CW{1'b0}}) && !retire_valid) begin
            state_r    <= ST_SLEEP;
            sleeping_r <= 1'b1;
          end else begin
            state_r    <= ST_WFI_DRAIN;
            sleeping_r <= 1'b0;
          end
        end
        ST_SLEEP: begin
          if (irq || flush) begin
            state_r    <= ST_RUN;
            sleeping_r <= 1'b0;
          end else begin
            state_r    <= ST_SLEEP;
            sleeping_r <= 1'b1;
          end
        end
        default: begin
          state_r    <= ST_RUN;
          sleeping_r <= 1'b0;
        end
      endcase
    end
  end

  // Issued-not-retired count; simultaneous issue and retire cancel, retire at 0 saturates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_r <= {CW{1'b0}};
    end else if (issue_s && !retire_valid) begin
      inflight_r <= inflight_r + CW'(1);
    end else if (retire_valid && !issue_s) begin
      if (inflight_r != {CW{1'b0}}) begin
        inflight_r <= inflight_r - CW'(1);
      end else begin
        inflight_r <= inflight_r;
      end
    end else begin
      inflight_r <= inflight_r;
    end
  end

  issue_ctrl_scoreboard #(
    .NumRegs  (NumRegs),
    .MaxCount (MaxInflight)
  ) u_scoreboard (
    .clk    (clk),
    .rst    (rst),
    .set    (sb_set_s),
    .set_rd (rd),
    .clr    (sb_clr_s),
    .clr_rd (retire_rd),
    .busy   (busy_s)
  );

  issue_ctrl_chk #(
    .MaxInflight (MaxInflight),
    .NumRegs     (NumRegs)
  ) u_chk (
    .clk             (clk),
    .rst             (rst),
    .issue_valid     (issue_s),
    .rd_valid        (rd_valid),
    .rd              (rd),
    .retire_valid    (retire_valid),
    .retire_rd_valid (retire_rd_valid),
    .retire_rd       (retire_rd),
    .inflight        (inflight_r),
    .busy            (busy_s)
  );

  assign issue_valid  = issue_s;
  assign id_ready     = ready_s;
  assign stall_hazard = stall_s;
  assign sleeping     = sleeping_r;
  assign inflight     = inflight_r;
  assign busy         = busy_s;

endmodule
